issue_stall_ctrl: RTL and testbench



---
 rtl/issue_stall_ctrl_pkg.sv | 36 +++
 rtl/issue_stall_ctrl_if.sv | 31 +++
 rtl/issue_stall_ctrl_instr_decode.sv | 28 ++
 rtl/issue_stall_ctrl.sv | 140 ++++++++++++++
 tb/tb_issue_stall_ctrl.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/issue_stall_ctrl_pkg.sv
// Shared types and constants for the issue/stall controller:
// opcodes, FSM states, decoded-instruction and scoreboard entry formats.
package hdu_pkg;

    localparam int NUM_INSTR = 8;
    localparam int HAZ_WIN   = 2;
    localparam int CNT_W     = 8;
    localparam int IDX_W     = $clog2(NUM_INSTR);
    localparam int DRAIN_W   = (HAZ_WIN > 1) ? $clog2(HAZ_WIN) : 1;

    localparam logic [1:0] OPC_NOP = 2'b00;
    localparam logic [1:0] OPC_MEM = 2'b01;
    localparam logic [1:0] OPC_SWP = 2'b10;
    localparam logic [1:0] OPC_ALU = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        DRAIN,
        DONE
    } state_e;

    typedef struct packed {
        logic [2:0] rs;
        logic [2:0] rd;
        logic       writes;
        logic       reads_rd;
    } decoded_t;

    typedef struct packed {
        logic       valid;
        logic [2:0] rd;
    } sb_entry_t;

endpackage

// File: rtl/issue_stall_ctrl_if.sv
// Load and issue handshake bundle between the instruction source,
// the stall controller and the pipeline fetch stage.
interface issue_stall_ctrl_if;
    import hdu_pkg::*;

    logic             start;
    logic             in_valid;
    logic [7:0]       in_byte;
    logic             in_ready;
    logic             pipe_ready;
    logic             issue_valid;
    logic [7:0]       issue_instr;
    logic [IDX_W-1:0] issue_idx;
    logic             stall;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output start, in_valid, in_byte, pipe_ready,
        input  in_ready, issue_valid, issue_instr, issue_idx,
               stall, busy, done, stall_count
    );

    modport slave (
        input  start, in_valid, in_byte, pipe_ready,
        output in_ready, issue_valid, issue_instr, issue_idx,
               stall, busy, done, stall_count
    );

endinterface

// File: rtl/issue_stall_ctrl_instr_decode.sv
// Combinational field decode of one 8-bit instruction into source,
// destination and read/write flags.
module instr_decode
    import hdu_pkg::*;
(
    input  logic [7:0] instr,
    output decoded_t   dec
);

    // SWP stores its fields swapped relative to every other opcode
    always_comb begin
        dec          = '0;
        dec.rd       = instr[5:3];
        dec.rs       = instr[2:0];
        dec.writes   = 1'b1;
        dec.reads_rd = 1'b0;
        unique case (instr[7:6])
            OPC_NOP: dec.writes = 1'b0;
            OPC_MEM: dec.reads_rd = 1'b1;
            OPC_SWP: begin
                dec.rs = instr[5:3];
                dec.rd = instr[2:0];
            end
            OPC_ALU: dec.writes = 1'b1;
        endcase
    end

endmodule

// File: rtl/issue_stall_ctrl.sv
// Loads an 8-instruction program byte-serially, then issues it in order,
// inserting bubbles while a RAW hazard against the in-flight window exists.
module issue_stall_ctrl
    import hdu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    issue_stall_ctrl_if.slave  bus
);

    state_e              state, state_next;
    logic [7:0]          instr_buf [NUM_INSTR];
    logic [IDX_W-1:0]    pc;
    logic [IDX_W-1:0]    load_cnt;
    logic [DRAIN_W-1:0]  drain_cnt;
    sb_entry_t           sb [HAZ_WIN];
    sb_entry_t           sb_in;
    logic                sb_shift;
    decoded_t            cur_dec;
    logic                hazard;

    logic                issue_valid_q;
    logic [7:0]          issue_instr_q;
    logic [IDX_W-1:0]    issue_idx_q;
    logic                stall_q;
    logic                done_q;
    logic [CNT_W-1:0]    stall_count_q;

    instr_decode u_decode (
        .instr (instr_buf[pc]),
        .dec   (cur_dec)
    );

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < HAZ_WIN; i++) begin
            if (sb[i].valid &&
                ((sb[i].rd == cur_dec.rs) ||
                 (cur_dec.reads_rd && (sb[i].rd == cur_dec.rd)))) begin
                hazard = 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        sb_shift   = 1'b0;
        sb_in      = '0;
        unique case (state)
            IDLE: if (bus.start) state_next = LOAD;
            LOAD: if (bus.in_valid && (load_cnt == IDX_W'(NUM_INSTR - 1))) state_next = RUN;
            RUN: if (bus.pipe_ready) begin
                sb_shift = 1'b1;
                if (!hazard) begin
                    sb_in = '{valid: cur_dec.writes, rd: cur_dec.rd};
                    if (pc == IDX_W'(NUM_INSTR - 1)) state_next = DRAIN;
                end
            end
            DRAIN: if (bus.pipe_ready) begin
                sb_shift = 1'b1;
                if (drain_cnt == DRAIN_W'(HAZ_WIN - 1)) state_next = DONE;
            end
            DONE: state_next = IDLE;
        endcase
    end

    // Program storage is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (state == LOAD && bus.in_valid) begin
            instr_buf[load_cnt] <= bus.in_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < HAZ_WIN; i++) sb[i] <= '0;
        end else if (sb_shift) begin
            for (int i = HAZ_WIN - 1; i > 0; i--) sb[i] <= sb[i-1];
            sb[0] <= sb_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            pc            <= '0;
            load_cnt      <= '0;
            drain_cnt     <= '0;
            issue_valid_q <= 1'b0;
            issue_instr_q <= '0;
            issue_idx_q   <= '0;
            stall_q       <= 1'b0;
            done_q        <= 1'b0;
            stall_count_q <= '0;
        end else begin
            state  <= state_next;
            done_q <= (state == DONE);
            unique case (state)
                IDLE: if (bus.start) begin
                    pc            <= '0;
                    load_cnt      <= '0;
                    drain_cnt     <= '0;
                    stall_count_q <= '0;
                end
                LOAD: if (bus.in_valid) load_cnt <= load_cnt + IDX_W'(1);
                RUN: if (bus.pipe_ready) begin
                    if (hazard) begin
                        issue_valid_q <= 1'b0;
                        stall_q       <= 1'b1;
                        if (stall_count_q != {CNT_W{1'b1}}) begin
                            stall_count_q <= stall_count_q + CNT_W'(1);
                        end
                    end else begin
                        issue_valid_q <= 1'b1;
                        stall_q       <= 1'b0;
                        issue_instr_q <= instr_buf[pc];
                        issue_idx_q   <= pc;
                        pc            <= pc + IDX_W'(1);
                    end
                end
                DRAIN: if (bus.pipe_ready) begin
                    issue_valid_q <= 1'b0;
                    stall_q       <= 1'b0;
                    drain_cnt     <= drain_cnt + DRAIN_W'(1);
                end
                DONE: ;
            endcase
        end
    end

    assign bus.in_ready    = (state == LOAD);
    assign bus.busy        = (state != IDLE);
    assign bus.issue_valid = issue_valid_q;
    assign bus.issue_instr = issue_instr_q;
    assign bus.issue_idx   = issue_idx_q;
    assign bus.stall       = stall_q;
    assign bus.done        = done_q;
    assign bus.stall_count = stall_count_q;

endmodule

// File: tb/tb_issue_stall_ctrl.sv
// Self-checking bench for issue_stall_ctrl: a slot-timing model fills an
// expectation queue at load time, and each issue slot is popped and compared.
module tb_issue_stall_ctrl;
    import hdu_pkg::*;

    localparam logic [1:0] K_ISSUE  = 2'd0;
    localparam logic [1:0] K_BUBBLE = 2'd1;
    localparam logic [1:0] K_DRAIN  = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] instr;
        logic [2:0] idx;
    } sched_t;

    logic clk = 1'b0;
    logic rst;
    int   cycle   = 0;
    int   passed  = 0;
    int   total   = 0;

    sched_t           exp_q [$];
    logic [7:0]       exp_instr;
    logic [2:0]       exp_idx;
    logic [CNT_W-1:0] exp_count;
    logic [7:0]       prog [8];

    issue_stall_ctrl_if bus ();

    issue_stall_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    // Slot-time model: an instruction may issue only once every register it
    // reads was last written more than HAZ_WIN slots earlier.
    task automatic build_expect(input logic [7:0] p [8]);
        int         last_wr [8];
        int         slot;
        logic [1:0] opc;
        logic [2:0] src, dst;
        logic       blocked;
        sched_t     e;
        slot = 0;
        for (int r = 0; r < 8; r++) last_wr[r] = -100;
        for (int k = 0; k < 8; k++) begin
            opc = p[k][7:6];
            if (opc == 2'b10) begin src = p[k][5:3]; dst = p[k][2:0]; end
            else              begin src = p[k][2:0]; dst = p[k][5:3]; end
            for (int b = 0; b < 10; b++) begin
                blocked = ((slot - last_wr[src]) <= HAZ_WIN) ||
                          ((opc == 2'b01) && ((slot - last_wr[dst]) <= HAZ_WIN));
                if (!blocked) break;
                e = '{kind: K_BUBBLE, instr: 8'h00, idx: 3'd0};
                exp_q.push_back(e);
                slot++;
            end
            e = '{kind: K_ISSUE, instr: p[k], idx: 3'(k)};
            exp_q.push_back(e);
            if (opc != 2'b00) last_wr[dst] = slot;
            slot++;
        end
        for (int d = 0; d < HAZ_WIN; d++) begin
            e = '{kind: K_DRAIN, instr: 8'h00, idx: 3'd0};
            exp_q.push_back(e);
        end
    endtask

    task automatic load_program(input logic [7:0] p [8], input logic poke_start);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        exp_count = '0;
        total++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL load_in_ready: got %b want 1", bus.in_ready); else passed++;
        total++; if (bus.stall_count !== exp_count) $display("[TB] FAIL load_count_clear: got %0d want %0d", bus.stall_count, exp_count); else passed++;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                bus.in_valid = 1'b0;
                bus.in_byte  = 8'hFF;
                step();
            end
            bus.in_valid = 1'b1;
            bus.in_byte  = p[i];
            bus.start    = poke_start && (i == 2);
            step();
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        total++; if (bus.in_ready !== 1'b0) $display("[TB] FAIL run_in_ready: got %b want 0", bus.in_ready); else passed++;
        total++; if (bus.busy !== 1'b1) $display("[TB] FAIL run_busy: got %b want 1", bus.busy); else passed++;
        build_expect(p);
    endtask

    task automatic run_program(input int hold_at, input int hold_len, input int abort_after, output int done_gap);
        sched_t e;
        logic   pr;
        logic   exp_valid;
        logic   exp_stall;
        int     hold_left;
        int     slots;
        int     budget;
        int     last_issue;
        exp_valid  = 1'b0;
        exp_stall  = 1'b0;
        hold_left  = hold_len;
        slots      = 0;
        budget     = 300;
        last_issue = cycle;
        done_gap   = -1;
        while (exp_q.size() > 0 && budget > 0) begin
            if (slots == hold_at && hold_left > 0) begin
                bus.pipe_ready = 1'b0;
                hold_left--;
            end else begin
                bus.pipe_ready = 1'b1;
            end
            pr = bus.pipe_ready;
            step();
            budget--;
            if (pr) begin
                e = exp_q.pop_front();
                slots++;
                exp_valid = (e.kind == K_ISSUE);
                exp_stall = (e.kind == K_BUBBLE);
                if (e.kind == K_ISSUE) begin
                    exp_instr  = e.instr;
                    exp_idx    = e.idx;
                    last_issue = cycle;
                end
                if (e.kind == K_BUBBLE && exp_count != {CNT_W{1'b1}}) exp_count++;
            end
            total++; if (bus.issue_valid !== exp_valid) $display("[TB] FAIL issue_valid@%0d: got %b want %b", cycle, bus.issue_valid, exp_valid); else passed++;
            total++; if (bus.stall !== exp_stall) $display("[TB] FAIL stall@%0d: got %b want %b", cycle, bus.stall, exp_stall); else passed++;
            total++; if (bus.issue_instr !== exp_instr) $display("[TB] FAIL issue_instr@%0d: got %h want %h", cycle, bus.issue_instr, exp_instr); else passed++;
            total++; if (bus.issue_idx !== exp_idx) $display("[TB] FAIL issue_idx@%0d: got %0d want %0d", cycle, bus.issue_idx, exp_idx); else passed++;
            total++; if (bus.stall_count !== exp_count) $display("[TB] FAIL stall_count@%0d: got %0d want %0d", cycle, bus.stall_count, exp_count); else passed++;
            total++; if (bus.busy !== 1'b1) $display("[TB] FAIL busy@%0d: got %b want 1", cycle, bus.busy); else passed++;
            total++; if (bus.done !== 1'b0) $display("[TB] FAIL early_done@%0d: got %b want 0", cycle, bus.done); else passed++;
            if (abort_after > 0 && slots >= abort_after) break;
        end
        if (abort_after > 0) return;
        total++; if (exp_q.size() != 0) $display("[TB] FAIL run_timeout: %0d slots left, want 0", exp_q.size()); else passed++;
        bus.pipe_ready = 1'b1;
        step();
        total++; if (bus.done !== 1'b1) $display("[TB] FAIL done_pulse: got %b want 1", bus.done); else passed++;
        total++; if (bus.busy !== 1'b0) $display("[TB] FAIL done_busy: got %b want 0", bus.busy); else passed++;
        done_gap = cycle - last_issue;
        step();
        total++; if (bus.done !== 1'b0) $display("[TB] FAIL done_width: got %b want 0", bus.done); else passed++;
    endtask

    task automatic check_zero_outputs(input string tag);
        total++; if (bus.issue_valid !== 1'b0) $display("[TB] FAIL %s_issue_valid: got %b want 0", tag, bus.issue_valid); else passed++;
        total++; if (bus.stall !== 1'b0) $display("[TB] FAIL %s_stall: got %b want 0", tag, bus.stall); else passed++;
        total++; if (bus.busy !== 1'b0) $display("[TB] FAIL %s_busy: got %b want 0", tag, bus.busy); else passed++;
        total++; if (bus.done !== 1'b0) $display("[TB] FAIL %s_done: got %b want 0", tag, bus.done); else passed++;
        total++; if (bus.in_ready !== 1'b0) $display("[TB] FAIL %s_in_ready: got %b want 0", tag, bus.in_ready); else passed++;
        total++; if (bus.issue_instr !== 8'h00) $display("[TB] FAIL %s_issue_instr: got %h want 00", tag, bus.issue_instr); else passed++;
        total++; if (bus.issue_idx !== 3'd0) $display("[TB] FAIL %s_issue_idx: got %0d want 0", tag, bus.issue_idx); else passed++;
        total++; if (bus.stall_count !== '0) $display("[TB] FAIL %s_stall_count: got %0d want 0", tag, bus.stall_count); else passed++;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus.start = 1'b1;
        step();
        step();
        check_zero_outputs("reset");
        rst       = 1'b0;
        bus.start = 1'b0;
        exp_instr = 8'h00;
        exp_idx   = 3'd0;
        exp_count = '0;
        step();
        total++; if (bus.busy !== 1'b0) $display("[TB] FAIL start_with_rst: got busy %b want 0", bus.busy); else passed++;
    endtask

    task automatic test_chain();
        int gap;
        prog = '{8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
        load_program(prog, 1'b0);
        run_program(99, 0, 0, gap);
        total++; if (bus.stall_count !== CNT_W'(14)) $display("[TB] FAIL chain_stalls: got %0d want 14", bus.stall_count); else passed++;
        total++; if (gap != 3) $display("[TB] FAIL chain_done_gap: got %0d want 3", gap); else passed++;
    endtask

    task automatic test_pair();
        int gap;
        prog = '{8'b11_011_001, 8'b11_100_011, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        load_program(prog, 1'b0);
        run_program(99, 0, 0, gap);
        total++; if (bus.stall_count !== CNT_W'(2)) $display("[TB] FAIL pair_stalls: got %0d want 2", bus.stall_count); else passed++;
    endtask

    task automatic test_distance2();
        int gap;
        prog = '{8'b11_011_001, 8'h00, 8'b10_011_101, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        load_program(prog, 1'b0);
        run_program(99, 0, 0, gap);
        total++; if (bus.stall_count !== CNT_W'(1)) $display("[TB] FAIL dist2_stalls: got %0d want 1", bus.stall_count); else passed++;
    endtask

    task automatic test_mem_reads_rd();
        int gap;
        prog = '{8'b11_010_000, 8'b01_010_111, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        load_program(prog, 1'b0);
        run_program(99, 0, 0, gap);
        total++; if (bus.stall_count !== CNT_W'(2)) $display("[TB] FAIL mem_rd_stalls: got %0d want 2", bus.stall_count); else passed++;
        prog = '{8'h00, 8'b01_010_111, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        load_program(prog, 1'b0);
        run_program(99, 0, 0, gap);
        total++; if (bus.stall_count !== CNT_W'(0)) $display("[TB] FAIL nop_producer_stalls: got %0d want 0", bus.stall_count); else passed++;
    endtask

    task automatic test_pipe_hold();
        int gap;
        prog = '{8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
        load_program(prog, 1'b0);
        run_program(4, 5, 0, gap);
        total++; if (bus.stall_count !== CNT_W'(14)) $display("[TB] FAIL hold_stalls: got %0d want 14", bus.stall_count); else passed++;
    endtask

    task automatic test_reset_mid_run();
        int gap;
        prog = '{8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
        load_program(prog, 1'b0);
        run_program(99, 0, 5, gap);
        rst = 1'b1;
        step();
        check_zero_outputs("midrun_rst");
        rst = 1'b0;
        exp_q.delete();
        exp_instr = 8'h00;
        exp_idx   = 3'd0;
        exp_count = '0;
        for (int i = 0; i < 4; i++) begin
            step();
            total++; if (bus.done !== 1'b0) $display("[TB] FAIL abort_done@%0d: got %b want 0", cycle, bus.done); else passed++;
        end
        bus.in_valid = 1'b1;
        bus.in_byte  = 8'hFF;
        step();
        total++; if (bus.in_ready !== 1'b0) $display("[TB] FAIL idle_in_ready: got %b want 0", bus.in_ready); else passed++;
        bus.in_valid = 1'b0;
        prog = '{8'b11_011_001, 8'b11_100_011, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        load_program(prog, 1'b1);
        run_program(99, 0, 0, gap);
        total++; if (bus.stall_count !== CNT_W'(2)) $display("[TB] FAIL reload_stalls: got %0d want 2", bus.stall_count); else passed++;
    endtask

    initial begin
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_byte    = 8'h00;
        bus.pipe_ready = 1'b0;
        exp_instr      = 8'h00;
        exp_idx        = 3'd0;
        exp_count      = '0;
        test_reset();
        test_chain();
        test_pair();
        test_distance2();
        test_mem_reads_rd();
        test_pipe_hold();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
